// File: rtl/uart_resp_tx_if.sv
// uart_resp_tx_if: response request handshake (req_valid/req_ready, cmd, len, payload), master drives requests, slave is the framer
interface uart_resp_tx_if #(parameter int MAX_PAYLOAD = 8);
  logic                     req_valid;
  logic                     req_ready;
  logic [7:0]               req_cmd;
  logic [3:0]               req_len;
  logic [8*MAX_PAYLOAD-1:0] req_payload;
  modport master (output req_valid, req_cmd, req_len, req_payload, input req_ready);
  modport slave (input req_valid, req_cmd, req_len, req_payload, output req_ready);
endinterface

// File: rtl/uart_resp_tx.sv
// uart_resp_tx: frames AA|LEN|CMD|PAYLOAD|CRC8 and sends it 8N1 on tx_o (ports: clk, rst, req slave if, tx_o, busy_o, frame_done_o); define RESP_GAP_EN for an idle gap after each frame
module uart_resp_tx #(
  parameter int         CLKS_PER_BIT = 32,
  parameter int         MAX_PAYLOAD  = 8,
  parameter logic [7:0] SYNC_BYTE    = 8'hAA,
  parameter int         GAP_BITS     = 2
) (
  input  logic           clk,
  input  logic           rst,
  uart_resp_tx_if.slave  req,
  output logic           tx_o,
  output logic           busy_o,
  output logic           frame_done_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = 8 * MAX_PAYLOAD;
  if (CLKS_PER_BIT < 2 || MAX_PAYLOAD < 1 || MAX_PAYLOAD > 15 || GAP_BITS < 1 || GAP_BITS > 15) begin : g_bad
    $error("uart_resp_tx: parameter out of range");
  end
  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_LEN, S_CMD, S_PAY, S_CRC
`ifdef RESP_GAP_EN
    , S_GAP
`endif
  } state_t;
  state_t        state_q, state_d;
  logic [7:0]    byte_q, byte_d, crc_q, crc_d, cmd_q, cmd_d;
  logic [3:0]    len_q, len_d, idx_q, idx_d, bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pay_q, pay_d;
  logic          cnt_end, byte_end, serial;
  logic [3:0]    len_c;
  logic [7:0]    len_byte;
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] x;
    x = c ^ d;
    for (int i = 0; i < 8; i++) x = x[7] ? (x << 1) ^ 8'h07 : x << 1;
    return x;
  endfunction
`ifdef RESP_GAP_EN
  assign serial = state_q != S_IDLE && state_q != S_GAP;
`else
  assign serial = state_q != S_IDLE;
`endif
  assign cnt_end       = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign byte_end      = cnt_end && bit_q == 4'd9;
  assign len_c         = req.req_len > 4'(MAX_PAYLOAD) ? 4'(MAX_PAYLOAD) : req.req_len;
  assign len_byte      = {4'd0, len_q} + 8'd2;
  assign req.req_ready = state_q == S_IDLE;
  assign busy_o        = state_q != S_IDLE;
  // bit_q: 0 start, 1..8 data LSB first, 9 stop
  assign tx_o = !serial || bit_q == 4'd9 ? 1'b1 : bit_q == 4'd0 ? 1'b0 : byte_q[3'(bit_q - 4'd1)];
  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    crc_d        = crc_q;
    cmd_d        = cmd_q;
    len_d        = len_q;
    idx_d        = idx_q;
    pay_d        = pay_q;
    frame_done_o = 1'b0;
    cnt_d        = state_q == S_IDLE ? cnt_q : cnt_end ? '0 : cnt_q + 1'b1;
    bit_d        = state_q == S_IDLE || !cnt_end ? bit_q : serial && bit_q == 4'd9 ? 4'd0 : bit_q + 4'd1;
    case (state_q)
      S_IDLE: if (req.req_valid) begin
        state_d = S_SYNC;
        byte_d  = SYNC_BYTE;
        crc_d   = 8'h00;
        cmd_d   = req.req_cmd;
        len_d   = len_c;
        pay_d   = req.req_payload;
        idx_d   = 4'd0;
        cnt_d   = '0;
        bit_d   = 4'd0;
      end
      S_SYNC: if (byte_end) begin
        state_d = S_LEN;
        byte_d  = len_byte;
        crc_d   = crc8(crc_q, len_byte);
      end
      S_LEN: if (byte_end) begin
        state_d = S_CMD;
        byte_d  = cmd_q;
        crc_d   = crc8(crc_q, cmd_q);
      end
      S_CMD: if (byte_end) begin
        state_d = len_q == 4'd0 ? S_CRC : S_PAY;
        byte_d  = len_q == 4'd0 ? crc_q : pay_q[7:0];
        crc_d   = len_q == 4'd0 ? crc_q : crc8(crc_q, pay_q[7:0]);
        pay_d   = pay_q >> 8;
        idx_d   = 4'd0;
      end
      S_PAY: if (byte_end) begin
        state_d = idx_q == len_q - 4'd1 ? S_CRC : S_PAY;
        byte_d  = idx_q == len_q - 4'd1 ? crc_q : pay_q[7:0];
        crc_d   = idx_q == len_q - 4'd1 ? crc_q : crc8(crc_q, pay_q[7:0]);
        idx_d   = idx_q == len_q - 4'd1 ? idx_q : idx_q + 4'd1;
        pay_d   = pay_q >> 8;
      end
      S_CRC: if (byte_end) begin
        frame_done_o = 1'b1;
`ifdef RESP_GAP_EN
        state_d = S_GAP;
`else
        state_d = S_IDLE;
`endif
      end
`ifdef RESP_GAP_EN
      S_GAP: if (cnt_end && bit_q == 4'(GAP_BITS - 1)) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      byte_q  <= 8'h00;
      crc_q   <= 8'h00;
      cmd_q   <= 8'h00;
      len_q   <= 4'd0;
      idx_q   <= 4'd0;
      bit_q   <= 4'd0;
      cnt_q   <= '0;
      pay_q   <= '0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      crc_q   <= crc_d;
      cmd_q   <= cmd_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      pay_q   <= pay_d;
    end
  end
endmodule

// File: tb/tb_uart_resp_tx.sv
// tb_uart_resp_tx: scoreboard bench decoding tx_o as 8N1 and comparing bytes, timing and handshake of uart_resp_tx
module tb_uart_resp_tx;
  localparam int CPB = 32;
  localparam int MP  = 8;
  localparam int BT  = 10 * CPB;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx, busy, done;
  int checks = 0, errors = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0, starts = 0;
  logic busy_prev = 1'b0;
  logic [7:0] exp_q[$];
  always #5 clk = ~clk;
  uart_resp_tx_if #(.MAX_PAYLOAD(MP)) bus ();
  uart_resp_tx #(.CLKS_PER_BIT(CPB), .MAX_PAYLOAD(MP)) dut (
    .clk(clk), .rst(rst), .req(bus), .tx_o(tx), .busy_o(busy), .frame_done_o(done)
  );
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (busy === 1'b1 && busy_prev !== 1'b1) begin
      start_cyc <= cyc;
      starts    <= starts + 1;
    end
    busy_prev <= busy;
  end
  function automatic logic [7:0] crc_upd(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    logic fb;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction
  task automatic rx_byte();
    logic [9:0] bits;
    logic v;
    bit bad;
    logic [7:0] e;
    bad = 0;
    v = 1'b1;
    @(negedge clk);
    if (rst || tx !== 1'b0) return;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (rst) return;
        if (c == 0) v = tx;
        else if (tx !== v) bad = 1;
      end
      bits[b] = v;
    end
    checks++;
    if (bad || bits[0] !== 1'b0 || bits[9] !== 1'b1) begin
      errors++;
      $display("FAIL framing bits=%b unstable=%0d want start 0, stop 1, each bit %0d clk", bits, bad, CPB);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_byte got %02h want none", bits[8:1]);
    end else begin
      e = exp_q.pop_front();
      if (bits[8:1] !== e) begin
        errors++;
        $display("FAIL byte got %02h want %02h", bits[8:1], e);
      end
    end
  endtask
  initial forever rx_byte();
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] cmd, input logic [3:0] len, input logic [8*MP-1:0] pay);
    int n, nn;
    logic [7:0] c, l;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20000) begin
      tick();
      n++;
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout ready=%b want 1", bus.req_ready);
      return;
    end
    nn = len > MP ? MP : int'(len);
    l = 8'(nn + 2);
    c = crc_upd(crc_upd(8'h00, l), cmd);
    exp_q.push_back(8'hAA);
    exp_q.push_back(l);
    exp_q.push_back(cmd);
    for (int k = 0; k < nn; k++) begin
      exp_q.push_back(pay[8*k +: 8]);
      c = crc_upd(c, pay[8*k +: 8]);
    end
    exp_q.push_back(c);
    bus.req_valid   = 1'b1;
    bus.req_cmd     = cmd;
    bus.req_len     = len;
    bus.req_payload = pay;
    tick();
    bus.req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || tx !== 1'b0 || bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL accept busy=%b tx=%b ready=%b want 1 0 0", busy, tx, bus.req_ready);
    end
  endtask
  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 20000) begin
      tick();
      n++;
    end
    checks++;
    if (done_cnt < target) begin
      errors++;
      $display("FAIL done_timeout count=%0d want %0d", done_cnt, target);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (10) begin
      tick();
      checks++;
      if (tx !== 1'b1 || bus.req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset tx=%b ready=%b busy=%b done=%b want 1 1 0 0", tx, bus.req_ready, busy, done);
      end
    end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_frame(input logic [7:0] cmd, input logic [3:0] len, input logic [8*MP-1:0] pay, input int nbytes);
    int d0;
    d0 = done_cnt;
    send(cmd, len, pay);
    wait_done(d0 + 1);
    checks++;
    if (done_cyc - start_cyc !== nbytes * BT - 1) begin
      errors++;
      $display("FAIL frame_len cmd=%02h got %0d want %0d", cmd, done_cyc - start_cyc + 1, nbytes * BT);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || bus.req_ready !== 1'b1 || tx !== 1'b1) begin
      errors++;
      $display("FAIL after_frame busy=%b ready=%b tx=%b want 0 1 1", busy, bus.req_ready, tx);
    end
    repeat (5) tick();
    checks++;
    if (done_cnt !== d0 + 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL frame_end dones=%0d want %0d, left=%0d want 0", done_cnt - d0, 1, exp_q.size());
    end
  endtask
  task automatic test_full_payload();
    logic [8*MP-1:0] p;
    for (int k = 0; k < MP; k++) p[8*k +: 8] = 8'((k + 1) * 8'h11);
    test_frame(8'h30, 4'd8, p, 12);
    test_frame(8'h30, 4'd9, p, 12);
    test_frame(8'h31, 4'd15, p, 12);
  endtask
  task automatic test_busy_ignore();
    int d0, s0;
    d0 = done_cnt;
    s0 = starts;
    send(8'h42, 4'd2, {48'h0, 16'hBEEF});
    repeat (600) tick();
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_busy ready=%b want 0", bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_cmd   = 8'hFF;
    bus.req_len   = 4'd1;
    tick();
    bus.req_valid = 1'b0;
    wait_done(d0 + 1);
    repeat (40) tick();
    checks++;
    if (starts !== s0 + 1 || busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL busy_ignore frames=%0d want 1, busy=%b want 0, left=%0d want 0", starts - s0, busy, exp_q.size());
    end
  endtask
  task automatic test_abort();
    int d0;
    logic [8*MP-1:0] p;
    p = 64'h0123_4567_89AB_CDEF;
    d0 = done_cnt;
    send(8'h5A, 4'd8, p);
    repeat (4 * BT + 100) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || done_cnt !== d0) begin
      errors++;
      $display("FAIL abort tx=%b busy=%b dones=%0d want 1 0 0", tx, busy, done_cnt - d0);
    end
    exp_q.delete();
    repeat (3) tick();
    test_frame(8'h01, 4'd0, '0, 4);
  endtask
  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt;
    send(8'h01, 4'd0, '0);
    send(8'h01, 4'd0, '0);
    checks++;
`ifdef RESP_GAP_EN
    if (start_cyc - (done_cyc + 1) < 2 * CPB) begin
      errors++;
      $display("FAIL gap got %0d want >= %0d", start_cyc - (done_cyc + 1), 2 * CPB);
    end
`else
    if (start_cyc - (done_cyc + 1) !== 1) begin
      errors++;
      $display("FAIL b2b_gap got %0d want 1", start_cyc - (done_cyc + 1));
    end
`endif
    wait_done(d0 + 2);
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0 || done_cnt !== d0 + 2) begin
      errors++;
      $display("FAIL b2b_end left=%0d dones=%0d want 0 2", exp_q.size(), done_cnt - d0);
    end
  endtask
  initial begin
    bus.req_valid   = 1'b0;
    bus.req_cmd     = 8'h00;
    bus.req_len     = 4'd0;
    bus.req_payload = '0;
    test_reset();
    test_frame(8'h01, 4'd0, '0, 4);
    test_frame(8'h07, 4'd1, '0, 5);
    test_full_payload();
    test_busy_ignore();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #900000;
    $display("FAIL watchdog time=%0t want finish earlier", $time);
    $fatal(1, "watchdog");
  end
endmodule
